// File: rtl/adder_share_arb.sv
// adder_share_arb: two requesters share one ripple adder. Round-robin grant,
// valid/ready handshakes, registered result tagged with the requester id.
// Optional feature: define ADDER_SHARE_CARRY_EN to add the res_carry output
// and its carry register; without it the overflow bit is dropped.

module nbit_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];
endmodule

// state | meaning
// IDLE  | waiting for a request; grant and ready are live
// ADD   | latched operands go through the adder; result registered at the edge
// HOLD  | result presented with res_valid until res_ready consumes it
module adder_share_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_id
`ifdef ADDER_SHARE_CARRY_EN
  ,
  output logic             res_carry
`endif
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       state;
  logic             last_id;
  logic             grant_valid;
  logic             grant_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] add_sum;
`ifdef ADDER_SHARE_CARRY_EN
  logic             add_cout;
`else
  logic             unused_add_cout;
`endif

  // Round-robin grant: a lone requester wins; on contention the one that did not go last wins
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_id;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign req0_ready = (state == S_IDLE) && req0_valid && !grant_id;
  assign req1_ready = (state == S_IDLE) && req1_valid &&  grant_id;

  nbit_adder #(.WIDTH(WIDTH)) u_adder (
    .a   (op_a),
    .b   (op_b),
    .cin (1'b0),
    .sum (add_sum),
`ifdef ADDER_SHARE_CARRY_EN
    .cout(add_cout)
`else
    .cout(unused_add_cout)
`endif
  );

  // Sequencer: accept in IDLE, register the sum in ADD, hand off in HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      last_id   <= 1'b1;
      op_a      <= '0;
      op_b      <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_id    <= 1'b0;
`ifdef ADDER_SHARE_CARRY_EN
      res_carry <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            op_a    <= grant_id ? req1_a : req0_a;
            op_b    <= grant_id ? req1_b : req0_b;
            res_id  <= grant_id;
            last_id <= grant_id;
            state   <= S_ADD;
          end
        end
        S_ADD: begin
          res_sum   <= add_sum;
`ifdef ADDER_SHARE_CARRY_EN
          res_carry <= add_cout;
`endif
          res_valid <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_share_arb.sv
// Testbench for adder_share_arb. A transaction-level model predicts readies
// and results each cycle; directed sequences pin known values.
// Honors ADDER_SHARE_CARRY_EN for the res_carry port.

module tb_adder_share_arb;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       v0, v1, rr;
  logic [7:0] a0, b0, a1, b1;
  logic       r0, r1, rv, rid;
  logic [7:0] rsum;
  logic       rcarry;

  logic       wv0, wv1, wrr;
  logic [0:0] wa0, wb0, wa1, wb1;
  logic       wr0, wr1, wrv, wid;
  logic [0:0] wsum;
  logic       wcarry;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // transaction-level model
  bit       m_have;
  int       m_age;
  bit       m_last;
  bit [7:0] m_sum;
  bit       m_id;
  bit       m_carry;
  bit       h0, h1, hres;
  int       res_id_q[$];
  int       res_cyc_q[$];

  always #5 clk = ~clk;

  adder_share_arb #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1),
    .res_valid(rv), .res_ready(rr), .res_sum(rsum), .res_id(rid)
`ifdef ADDER_SHARE_CARRY_EN
    , .res_carry(rcarry)
`endif
  );

  adder_share_arb #(.WIDTH(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(wv0), .req0_ready(wr0), .req0_a(wa0), .req0_b(wb0),
    .req1_valid(wv1), .req1_ready(wr1), .req1_a(wa1), .req1_b(wb1),
    .res_valid(wrv), .res_ready(wrr), .res_sum(wsum), .res_id(wid)
`ifdef ADDER_SHARE_CARRY_EN
    , .res_carry(wcarry)
`endif
  );

`ifndef ADDER_SHARE_CARRY_EN
  assign rcarry = 1'b0;
  assign wcarry = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_have = 1'b0;
    m_age  = 0;
    m_last = 1'b1;
    h0 = 1'b0; h1 = 1'b0; hres = 1'b0;
  endtask

  // One clock: compare at negedge against the model, then advance the model past the edge
  task automatic cycle();
    bit e0, e1, ev;
    int s;
    @(negedge clk);
    e0 = !m_have && v0 && (!v1 || m_last);
    e1 = !m_have && v1 && (!v0 || !m_last);
    ev = m_have && (m_age >= 2);
    check("req0_ready", 32'(r0), 32'(e0));
    check("req1_ready", 32'(r1), 32'(e1));
    check("res_valid", 32'(rv), 32'(ev));
    if (ev) begin
      check("res_sum", 32'(rsum), 32'(m_sum));
      check("res_id", 32'(rid), 32'(m_id));
`ifdef ADDER_SHARE_CARRY_EN
      check("res_carry", 32'(rcarry), 32'(m_carry));
`endif
    end
    h0 = v0 && e0;
    h1 = v1 && e1;
    hres = ev && rr;
    @(posedge clk);
    #1;
    if (m_have) begin
      if (hres) begin
        m_have = 1'b0;
        res_id_q.push_back(int'(m_id));
        res_cyc_q.push_back(cyc);
      end else begin
        m_age++;
      end
    end else if (h0 || h1) begin
      s = h0 ? (int'(a0) + int'(b0)) : (int'(a1) + int'(b1));
      m_sum   = s[7:0];
      m_carry = s[8];
      m_id    = h1;
      m_last  = h1;
      m_have  = 1'b1;
      m_age   = 1;
    end
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0;
    v0 = 0; v1 = 0; rr = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    wv0 = 0; wv1 = 0; wrr = 0; wa0 = 0; wb0 = 0; wa1 = 0; wb1 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_res_valid", 32'(rv), 0);
    check("rst_res_sum", 32'(rsum), 0);
    check("rst_res_id", 32'(rid), 0);
    check("rst_ready_any", 32'(r0 | r1), 0);
    rst_n = 1'b1;

    // WIDTH=1: 1+1 wraps to 0 with carry out
    wv0 = 1; wa0 = 1'b1; wb0 = 1'b1;
    @(posedge clk); #1;
    wv0 = 0;
    @(posedge clk); #1;
    check("w1_res_valid", 32'(wrv), 1);
    check("w1_res_sum", 32'(wsum), 0);
    check("w1_res_id", 32'(wid), 0);
`ifdef ADDER_SHARE_CARRY_EN
    check("w1_res_carry", 32'(wcarry), 1);
`endif
    wrr = 1;
    @(posedge clk); #1;
    check("w1_consumed", 32'(wrv), 0);

    // single request: 0x12 + 0x34
    v0 = 1; a0 = 8'h12; b0 = 8'h34;
    #1;
    check("t1_req0_ready", 32'(r0), 1);
    cycle();
    v0 = 0;
    cycle();
    check("t1_res_valid", 32'(rv), 1);
    check("t1_res_sum", 32'(rsum), 32'h46);
    check("t1_res_id", 32'(rid), 0);
    rr = 1;
    cycle();
    rr = 0;

    // overflow: 0xFF + 0x01
    v0 = 1; a0 = 8'hFF; b0 = 8'h01;
    cycle();
    v0 = 0;
    cycle();
    check("ovf_res_sum", 32'(rsum), 0);
`ifdef ADDER_SHARE_CARRY_EN
    check("ovf_res_carry", 32'(rcarry), 1);
`endif
    rr = 1;
    cycle();
    rr = 0;

    // consumer stalls 5 cycles with both requesters waiting
    v0 = 1; a0 = 8'd3; b0 = 8'd4;
    v1 = 1; a1 = 8'd5; b1 = 8'd6;
    cycle();
    v1 = 0;
    cycle();
    for (int k = 0; k < 5; k++) begin
      check("stall_ready_any", 32'(r0 | r1), 0);
      check("stall_res_valid", 32'(rv), 1);
      check("stall_res_sum", 32'(rsum), 32'd11);
      cycle();
    end
    rr = 1;
    cycle();
    rr = 0;
    check("after_consume_req0_ready", 32'(r0), 1);
    cycle();
    v0 = 0;
    rr = 1;
    cycle();
    cycle();
    rr = 0;

    // reset while holding a result
    v0 = 1; a0 = 8'h20; b0 = 8'h22;
    cycle();
    v0 = 0;
    cycle();
    check("pre_rst_res_valid", 32'(rv), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", 32'(rv), 0);
    check("mid_rst_res_sum", 32'(rsum), 0);
    check("mid_rst_res_id", 32'(rid), 0);
    check("mid_rst_carry", 32'(rcarry), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) cycle();

    // back-to-back contention with the consumer always ready
    res_id_q.delete();
    res_cyc_q.delete();
    v0 = 1; a0 = 8'($urandom); b0 = 8'($urandom);
    v1 = 1; a1 = 8'($urandom); b1 = 8'($urandom);
    rr = 1;
    h0 = 0; h1 = 0;
    for (int k = 0; k < 14; k++) begin
      if (h0) begin a0 = 8'($urandom); b0 = 8'($urandom); end
      if (h1) begin a1 = 8'($urandom); b1 = 8'($urandom); end
      cycle();
    end
    check("tput_result_count_ge4", 32'(res_id_q.size() >= 4), 1);
    if (res_id_q.size() >= 4) begin
      for (int k = 0; k < 4; k++) check("tput_res_id_order", 32'(res_id_q[k]), 32'(k % 2));
      for (int k = 0; k < 3; k++) check("tput_result_spacing", 32'(res_cyc_q[k+1] - res_cyc_q[k]), 3);
    end
    v0 = 0; v1 = 0;
    repeat (4) cycle();

    // randomized traffic obeying the hold-until-ready rule
    h0 = 0; h1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (h0 || !v0) begin
        if ($urandom_range(1) == 1) begin
          v0 = 1; a0 = 8'($urandom); b0 = 8'($urandom);
        end else begin
          v0 = 0;
        end
      end
      if (h1 || !v1) begin
        if ($urandom_range(1) == 1) begin
          v1 = 1; a1 = 8'($urandom); b1 = 8'($urandom);
        end else begin
          v1 = 0;
        end
      end
      rr = ($urandom_range(3) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
